// File: rtl/score_digit_scheduler.sv
// score_digit_scheduler
//
// Converts a binary value to BCD with shift-and-add-3. It commits the digits to the
// display registers only at a frame boundary, so a frame never shows a half-updated
// value. For every pixel it also reports which digit glyph covers that pixel and the
// pixel's position inside the glyph.
//
// Ports:
//   clk_i           pixel/system clock
//   reset_ni        synchronous active-low reset
//   value_valid_i   new value offered (producer holds it until value_ready_o)
//   value_i         binary value to display
//   value_ready_o   block can accept a value (idle)
//   frame_start_i   one-cycle pulse at the start of vertical blanking
//   x_i, y_i        current pixel column / row
//   busy_o          conversion or commit pending
//   overflow_o      displayed value is saturated to all nines
//   digit_active_o  pixel lies inside a shown digit cell (registered)
//   digit_o         BCD digit to render (registered)
//   glyph_x_o       column inside the glyph (registered)
//   glyph_y_o       row inside the glyph (registered)
module score_digit_scheduler #(
    parameter int unsigned DIGITS      = 6,
    parameter int unsigned VALUE_W     = 20,
    parameter int unsigned ORIGIN_X    = 16,
    parameter int unsigned ORIGIN_Y    = 8,
    parameter int unsigned GLYPH_W     = 12,
    parameter int unsigned GLYPH_H     = 17,
    parameter int unsigned BLANK_ZEROS = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               value_valid_i,
    input  logic [VALUE_W-1:0] value_i,
    output logic               value_ready_o,
    input  logic               frame_start_i,
    input  logic [31:0]        x_i,
    input  logic [31:0]        y_i,
    output logic               busy_o,
    output logic               overflow_o,
    output logic               digit_active_o,
    output logic [3:0]         digit_o,
    output logic [3:0]         glyph_x_o,
    output logic [4:0]         glyph_y_o
);

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    localparam logic [63:0]     SatLimit = pow10(DIGITS);
    localparam int unsigned     BcdW     = 4 * DIGITS;
    localparam int unsigned     CntW     = $clog2(VALUE_W + 1);
    localparam logic [CntW-1:0] LastIter = CntW'(VALUE_W - 1);

    typedef enum logic [1:0] {StIdle, StConvert, StWaitFrame, StCommit} state_e;

    state_e             state_q;
    logic [VALUE_W-1:0] shreg_q;
    logic [BcdW-1:0]    bcd_q;
    logic [BcdW-1:0]    bcd_adj;
    logic [CntW-1:0]    cnt_q;
    logic               sat_q;
    logic               overflow_q;
    logic [3:0]         disp_q [DIGITS];

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                disp_q[i] <= 4'd0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (value_valid_i) begin
                        shreg_q <= value_i;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        sat_q   <= (64'(value_i) >= SatLimit);
                        state_q <= StConvert;
                    end
                end
                StConvert: begin
                    // The BCD MSB shifted out is only ever non-zero for saturated values.
                    bcd_q   <= (bcd_adj << 1) | BcdW'(shreg_q[VALUE_W-1]);
                    shreg_q <= shreg_q << 1;
                    if (cnt_q == LastIter) begin
                        state_q <= StWaitFrame;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitFrame: begin
                    if (frame_start_i) begin
                        state_q <= StCommit;
                    end
                end
                StCommit: begin
                    // Cell 0 is the most significant digit, i.e. the top nibble.
                    for (int unsigned i = 0; i < DIGITS; i++) begin
                        disp_q[i] <= sat_q ? 4'd9 : bcd_q[4*(DIGITS-1-i) +: 4];
                    end
                    overflow_q <= sat_q;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign value_ready_o = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign overflow_o    = overflow_q;

    // Pixel mapping: one range compare per cell, no divider.
    logic        active_d, active_q;
    logic [3:0]  digit_d, digit_q;
    logic [3:0]  gx_d, gx_q;
    logic [4:0]  gy_d, gy_q;
    logic [31:0] gy_full;
    logic [31:0] cell_lo;
    logic        in_y;
    logic        lead_zero;

    always_comb begin
        active_d  = 1'b0;
        digit_d   = 4'd0;
        gx_d      = 4'd0;
        gy_d      = 5'd0;
        lead_zero = 1'b1;
        cell_lo   = '0;
        gy_full   = y_i - 32'(ORIGIN_Y);
        in_y      = (y_i >= 32'(ORIGIN_Y)) && (gy_full < 32'(GLYPH_H));
        for (int unsigned i = 0; i < DIGITS; i++) begin
            // Running "this cell and everything left of it is zero".
            lead_zero = lead_zero && (disp_q[i] == 4'd0);
            cell_lo   = 32'(ORIGIN_X) + 32'(i) * 32'(GLYPH_W);
            if (in_y && (x_i >= cell_lo) && (x_i < cell_lo + 32'(GLYPH_W)) &&
                !((BLANK_ZEROS != 0) && lead_zero && (i != DIGITS - 1))) begin
                active_d = 1'b1;
                digit_d  = disp_q[i];
                gx_d     = 4'(x_i - cell_lo);
                gy_d     = 5'(gy_full);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            active_q <= 1'b0;
            digit_q  <= 4'd0;
            gx_q     <= 4'd0;
            gy_q     <= 5'd0;
        end else begin
            active_q <= active_d;
            digit_q  <= digit_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
        end
    end

    assign digit_active_o = active_q;
    assign digit_o        = digit_q;
    assign glyph_x_o      = gx_q;
    assign glyph_y_o      = gy_q;

endmodule

// File: tb/tb_score_digit_scheduler.sv
module tb_score_digit_scheduler;

    localparam int unsigned NDIG = 6;

    logic        clk;
    logic        reset_n;
    logic        value_valid;
    logic [19:0] value;
    logic        value_ready;
    logic        frame_start;
    logic [31:0] x;
    logic [31:0] y;
    logic        busy;
    logic        overflow;
    logic        digit_active;
    logic [3:0]  digit;
    logic [3:0]  glyph_x;
    logic [4:0]  glyph_y;

    score_digit_scheduler dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .value_valid_i  (value_valid),
        .value_i        (value),
        .value_ready_o  (value_ready),
        .frame_start_i  (frame_start),
        .x_i            (x),
        .y_i            (y),
        .busy_o         (busy),
        .overflow_o     (overflow),
        .digit_active_o (digit_active),
        .digit_o        (digit),
        .glyph_x_o      (glyph_x),
        .glyph_y_o      (glyph_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       act;
        logic [3:0] dig;
        logic [3:0] gx;
        logic [4:0] gy;
    } pix_t;

    pix_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned disp_m [NDIG];
    int unsigned ov_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference display: plain decimal digit extraction with saturation.
    task automatic model_commit(input int unsigned v);
        int unsigned t;
        t = v;
        if (v >= 1000000) begin
            for (int i = 0; i < NDIG; i++) disp_m[i] = 9;
            ov_m = 1;
        end else begin
            for (int i = NDIG - 1; i >= 0; i--) begin
                disp_m[i] = t % 10;
                t = t / 10;
            end
            ov_m = 0;
        end
    endtask

    function automatic pix_t pix_model(input int unsigned px, input int unsigned py,
                                       input string tag);
        pix_t        r;
        int unsigned c;
        bit          lead;
        r.tag = tag;
        r.act = 1'b0;
        r.dig = 4'd0;
        r.gx  = 4'd0;
        r.gy  = 5'd0;
        if (px >= 16 && py >= 8 && py < 25) begin
            c = (px - 16) / 12;
            if (c < NDIG) begin
                lead = 1'b1;
                for (int unsigned j = 0; j <= c; j++) lead = lead && (disp_m[j] == 0);
                if (!(lead && c != NDIG - 1)) begin
                    r.act = 1'b1;
                    r.dig = 4'(disp_m[c]);
                    r.gx  = 4'((px - 16) - c * 12);
                    r.gy  = 5'(py - 8);
                end
            end
        end
        return r;
    endfunction

    // Drive a pixel, queue the model's answer, compare one cycle later.
    task automatic probe(input int unsigned px, input int unsigned py, input string tag);
        pix_t e;
        x = px;
        y = py;
        sb.push_back(pix_model(px, py, tag));
        cyc();
        e = sb.pop_front();
        chk({e.tag, ".active"}, 32'(digit_active), 32'(e.act));
        chk({e.tag, ".digit"},  32'(digit),        32'(e.dig));
        chk({e.tag, ".gx"},     32'(glyph_x),      32'(e.gx));
        chk({e.tag, ".gy"},     32'(glyph_y),      32'(e.gy));
    endtask

    task automatic probe_cell(input int unsigned c, input int unsigned gx,
                              input int unsigned gy, input string tag);
        probe(16 + c * 12 + gx, 8 + gy, tag);
    endtask

    task automatic accept(input int unsigned v, input string tag);
        chk({tag, ".ready_before"}, 32'(value_ready), 32'(1));
        value_valid = 1'b1;
        value       = 20'(v);
        cyc();
        value_valid = 1'b0;
        chk({tag, ".ready_after"}, 32'(value_ready), 32'(0));
        chk({tag, ".busy_after"},  32'(busy),        32'(1));
    endtask

    task automatic commit_frame(input int unsigned v, input string tag);
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        chk({tag, ".busy_commit"}, 32'(busy), 32'(1));
        cyc();
        model_commit(v);
        chk({tag, ".busy_done"},  32'(busy),        32'(0));
        chk({tag, ".ready_done"}, 32'(value_ready), 32'(1));
        chk({tag, ".overflow"},   32'(overflow),    32'(ov_m));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n     = 1'b0;
        value_valid = 1'b0;
        value       = '0;
        frame_start = 1'b0;
        x           = 76;
        y           = 8;
        for (int i = 0; i < NDIG; i++) disp_m[i] = 0;
        @(posedge clk);
        cyc();
        cyc();
        chk("rst.busy",     32'(busy),         32'(0));
        chk("rst.overflow", 32'(overflow),     32'(0));
        chk("rst.active",   32'(digit_active), 32'(0));
        chk("rst.digit",    32'(digit),        32'(0));
        chk("rst.gx",       32'(glyph_x),      32'(0));
        chk("rst.gy",       32'(glyph_y),      32'(0));
        reset_n = 1'b1;
        chk("rst.ready", 32'(value_ready), 32'(1));
        probe(76, 8, "rst.cell5");
        for (int unsigned c = 0; c < 5; c++) probe_cell(c, 2, 3, "rst.blank");

        // 123456, frame pulse 30 cycles after the accept edge.
        accept(123456, "v123456");
        repeat (28) begin
            cyc();
            chk("v123456.busy_wait", 32'(busy), 32'(1));
        end
        probe_cell(5, 3, 4, "v123456.old");
        commit_frame(123456, "v123456");
        for (int unsigned c = 0; c < NDIG; c++) probe_cell(c, 5, 9, "v123456.cell");

        probe(15, 8, "edge.x15");
        probe(16, 8, "edge.x16");
        probe(27, 8, "edge.x27");
        probe(28, 8, "edge.x28");
        probe(87, 24, "edge.x87y24");
        probe(88, 8, "edge.x88");
        probe(20, 25, "edge.y25");
        probe(20, 7, "edge.y7");

        // Saturation; frame pulse on the very first WAIT_FRAME cycle.
        accept(1000000, "sat");
        repeat (20) cyc();
        commit_frame(1000000, "sat");
        for (int unsigned c = 0; c < NDIG; c++) probe_cell(c, 0, 16, "sat.cell");

        // 42 with value_valid held and a frame pulse during CONVERT.
        value_valid = 1'b1;
        value       = 20'd42;
        cyc();
        repeat (18) begin
            chk("v42.ready_held", 32'(value_ready), 32'(0));
            cyc();
        end
        value_valid = 1'b0;
        cyc();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        chk("v42.busy_ignored", 32'(busy), 32'(1));
        probe_cell(5, 1, 1, "v42.unchanged");
        commit_frame(42, "v42");
        for (int unsigned c = 0; c < NDIG; c++) probe_cell(c, 6, 6, "v42.cell");

        // Reset during the conversion of a new value.
        accept(5, "abort");
        repeat (9) cyc();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("abort.busy",     32'(busy),        32'(0));
        chk("abort.ready",    32'(value_ready), 32'(1));
        chk("abort.overflow", 32'(overflow),    32'(0));
        for (int i = 0; i < NDIG; i++) disp_m[i] = 0;
        probe_cell(5, 4, 4, "abort.cell5");
        probe_cell(4, 4, 4, "abort.cell4");
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        cyc();
        chk("abort.busy_late", 32'(busy), 32'(0));
        probe_cell(5, 7, 2, "abort.late5");
        probe_cell(0, 7, 2, "abort.late0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/score_digit_scheduler.md
# score_digit_scheduler

Sequencing controller for the on-screen numeric readouts (score, coins, timer). It accepts a binary value through a valid/ready handshake and converts it to BCD iteratively (shift-and-add-3). At a frame boundary it commits the digits to tear-free display registers. Per pixel, it tells the downstream glyph renderer which digit (0–9) to draw and where inside the glyph the pixel falls. It sits between the game-state logic and the per-digit glyph renderers in the VGA pixel path.

## Interface
Parameters:
- DIGITS, 6, number of displayed decimal digits (1–8)
- VALUE_W, 20, width of the binary input value
- ORIGIN_X, 16, left pixel column of the most significant digit
- ORIGIN_Y, 8, top pixel row of the readout
- GLYPH_W, 12, glyph width in pixels
- GLYPH_H, 17, glyph height in pixels
- BLANK_ZEROS, 1, 1 = suppress leading zeros (least significant digit always shown)

Ports:
- clk  in  1  pixel/system clock
- reset_n  in  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- value_valid  in  1  new value offered
- value  in  VALUE_W  binary value to display
- value_ready  out  1  high when the block can accept a value (IDLE state)
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- x  in  32  current pixel column
- y  in  32  current pixel row
- busy  out  1  conversion or commit pending
- overflow  out  1  displayed value is saturated
- digit_active  out  1  current pixel lies inside a shown digit cell
- digit  out  4  BCD digit to render at the current pixel
- glyph_x  out  4  column within the glyph, 0..GLYPH_W-1
- glyph_y  out  5  row within the glyph, 0..GLYPH_H-1

## Operation
- FSM states: IDLE, CONVERT, WAIT_FRAME, COMMIT.
- IDLE:
  - value_ready=1.
  - On value_valid&value_ready, latch value into the shift register and clear the BCD accumulator.
  - If value ≥ 10^DIGITS, set a sat flag.
  - Go to CONVERT.
- CONVERT:
  - Each cycle, for every BCD nibble ≥5, add 3; then shift {bcd, shreg} left by 1.
  - Runs exactly VALUE_W cycles (iteration counter), then goes to WAIT_FRAME.
- WAIT_FRAME:
  - Hold the result.
  - Go to COMMIT on the first cycle frame_start=1.
  - frame_start in any other state is ignored.
- COMMIT (1 cycle):
  - Copy the BCD result to the display registers; if sat, load all 9s instead.
  - overflow<=sat.
  - Return to IDLE.
- The display registers are the only source for pixel outputs. The previous value stays shown until COMMIT.
- busy=1 in CONVERT, WAIT_FRAME and COMMIT.
- Pixel mapping:
  - Cell i (i=0 is leftmost, most significant) spans x∈[ORIGIN_X+i·GLYPH_W, ORIGIN_X+(i+1)·GLYPH_W) and y∈[ORIGIN_Y, ORIGIN_Y+GLYPH_H).
  - Cell selection uses DIGITS parallel range compares, not a divider.
  - glyph_x=x−cell start; glyph_y=y−ORIGIN_Y.
  - All arithmetic is unsigned 32-bit; x<ORIGIN_X or y<ORIGIN_Y is outside.
- Blanking (BLANK_ZEROS=1):
  - A cell is blanked if it and all cells to its left hold 0, except cell DIGITS−1.
  - Blanked or outside pixels give digit_active=0 and digit/glyph_x/glyph_y=0.

## Timing
- Reset:
  - state=IDLE; display registers=0.
  - overflow=0, busy=0, digit_active=0, digit=0, glyph_x=0, glyph_y=0.
  - value_ready=1 in the first cycle after reset is released.
- Reset asserted mid-conversion aborts the conversion: the display returns to 0 and the pending value is discarded.
- Accept-to-result: VALUE_W cycles in CONVERT after the accept edge, then WAIT_FRAME.
- Display update happens at the clk edge following the first frame_start seen in WAIT_FRAME.
- value_ready is 0 from the accept edge until the cycle after COMMIT. Offered values are not dropped; the producer holds value_valid.
- Pixel outputs are registered: 1-cycle latency from x/y to digit_active/digit/glyph_x/glyph_y.
- Display registers change only at COMMIT, during blanking, so there is no mid-frame tearing.

## Test plan
- Reset released, x=ORIGIN_X+5·12, y=8 → next cycle digit_active=1, digit=0, glyph_x=0, glyph_y=0; cells 0–4 blanked; value_ready=1.
- value=123456 accepted, frame_start pulsed 30 cycles later → COMMIT follows the pulse; cell 0 gives digit=1, cell 5 gives digit=6; overflow=0.
- value=1000000 → all cells show 9, overflow=1; value=42 next → cells 4,5 show 4,2, cells 0–3 blanked, overflow=0.
- Pixel boundaries: x=15 → inactive; x=16 → cell 0, glyph_x=0; x=27 → glyph_x=11; x=28 → cell 1, glyph_x=0; x=88 or y=25 → inactive.
- value_valid held during CONVERT → value_ready=0, no second accept until IDLE; frame_start pulsed during CONVERT → ignored, display unchanged.
- reset_n low at CONVERT cycle 10 → next cycle state IDLE, display 0, busy=0; no commit on a later frame_start.
